lut_coeff_bank: RTL and testbench

- Parametrised multi-channel coefficient lookup table for the range-limited force pipeline.
- Holds NUM_COEFF coefficient tables (e.g. c14/c8 terms or interpolation c0..c2), all indexed by one shared segment address.
- Each read request returns all channels together, with a sideband tag for matching the result to its request.
- Supports runtime reload of table contents through a streaming load port, so no re-synthesis is needed to change coefficients.

---
 rtl/lut_coeff_pkg.sv | 21 ++
 rtl/lut_bank_ram.sv | 29 ++
 rtl/lut_coeff_bank.sv | 171 +++++++++++++++++
 tb/tb_lut_coeff_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lut_coeff_pkg.sv
// Shared widths, load-FSM encoding and channel slicing helper for the
// range-limited force coefficient bank.
package lut_coeff_pkg;

  localparam int DEF_NUM_COEFF  = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 3072;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_TAG_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  function automatic int unsigned ch_offset(input int unsigned ch, input int unsigned dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/lut_bank_ram.sv
// One coefficient channel: single-port inferred RAM, registered read-first
// output, so a read of an entry being written returns the old word.
module lut_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3072,
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/lut_coeff_bank.sv
// Multi-channel coefficient LUT: shared-address 2-cycle read pipeline with
// tag/out-of-range sideband, plus a streaming address-major reload port.
module lut_coeff_bank
  import lut_coeff_pkg::*;
#(
  parameter int NUM_COEFF  = DEF_NUM_COEFF,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [TAG_WIDTH-1:0]            rd_tag,
  output logic                            out_valid,
  output logic [NUM_COEFF*DATA_WIDTH-1:0] out_q,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic                            out_oor,
  input  logic                            ld_start,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic                            ld_done
);

  localparam int CH_W   = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(NUM_COEFF - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);

  ld_state_e             state_q;
  logic                  rd_ready_q, ld_ready_q, ld_done_q;
  logic [CH_W-1:0]       ch_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_cnt_q;

  logic rd_fire, ld_fire, rd_oor, ld_last;

  assign rd_fire = rd_valid & rd_ready_q;
  assign ld_fire = ld_valid & ld_ready_q;
  assign rd_oor  = {1'b0, rd_addr} >= DEPTH_X;
  assign ld_last = (ch_cnt_q == LAST_CH) && (addr_cnt_q == LAST_ADDR);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ready_q <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ch_cnt_q   <= '0;
      addr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (ld_start) begin
          state_q    <= ST_LOAD;
          rd_ready_q <= 1'b0;
          ld_ready_q <= 1'b1;
          ch_cnt_q   <= '0;
          addr_cnt_q <= '0;
        end
        ST_LOAD: if (ld_fire) begin
          if (ld_last) begin
            state_q    <= ST_DONE;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b1;
          end else if (ch_cnt_q == LAST_CH) begin
            ch_cnt_q   <= '0;
            addr_cnt_q <= addr_cnt_q + 1'b1;
          end else begin
            ch_cnt_q <= ch_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          ld_done_q  <= 1'b0;
          rd_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          rd_ready_q <= 1'b1;
          ld_ready_q <= 1'b0;
          ld_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reads and writes never share a cycle (rd_ready and ld_ready are exclusive),
  // so one address port serves both; out-of-range reads never enable the RAM.
  logic [RAM_AW-1:0]                     ram_addr;
  logic [NUM_COEFF-1:0]                  ram_en, ram_we;
  logic [NUM_COEFF-1:0][DATA_WIDTH-1:0]  ram_dout;

  always_comb begin
    ram_addr = (state_q == ST_LOAD) ? addr_cnt_q[RAM_AW-1:0] : rd_addr[RAM_AW-1:0];
    ram_we   = '0;
    ram_en   = '0;
    for (int i = 0; i < NUM_COEFF; i++) begin
      ram_we[i] = ld_fire && (ch_cnt_q == CH_W'(i));
      ram_en[i] = ram_we[i] | (rd_fire & ~rd_oor);
    end
  end

  for (genvar g = 0; g < NUM_COEFF; g++) begin : g_bank
    lut_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (RAM_AW),
      .INIT_FILE  ("")
    ) u_ram (
      .clock (clock),
      .en    (ram_en[g]),
      .we    (ram_we[g]),
      .addr  (ram_addr),
      .din   (ld_data),
      .dout  (ram_dout[g])
    );
  end

  logic                            s1_vld_d, s1_vld_q, s1_oor_d, s1_oor_q;
  logic [TAG_WIDTH-1:0]            s1_tag_d, s1_tag_q;
  logic                            out_vld_d, out_vld_q, out_oor_d, out_oor_q;
  logic [TAG_WIDTH-1:0]            out_tag_d, out_tag_q;
  logic [NUM_COEFF*DATA_WIDTH-1:0] out_q_d, out_q_q;

  always_comb begin
    s1_vld_d  = rd_fire;
    s1_tag_d  = rd_fire ? rd_tag : s1_tag_q;
    s1_oor_d  = rd_fire ? rd_oor : s1_oor_q;
    out_vld_d = s1_vld_q;
    out_tag_d = s1_vld_q ? s1_tag_q : out_tag_q;
    out_oor_d = s1_vld_q ? s1_oor_q : out_oor_q;
    out_q_d   = out_q_q;
    if (s1_vld_q) begin
      for (int i = 0; i < NUM_COEFF; i++)
        out_q_d[ch_offset(i, DATA_WIDTH) +: DATA_WIDTH] = s1_oor_q ? '0 : ram_dout[i];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_tag_q  <= '0;
      s1_oor_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_tag_q <= '0;
      out_oor_q <= 1'b0;
      out_q_q   <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_tag_q  <= s1_tag_d;
      s1_oor_q  <= s1_oor_d;
      out_vld_q <= out_vld_d;
      out_tag_q <= out_tag_d;
      out_oor_q <= out_oor_d;
      out_q_q   <= out_q_d;
    end
  end

  assign rd_ready  = rd_ready_q;
  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign out_valid = out_vld_q;
  assign out_q     = out_q_q;
  assign out_tag   = out_tag_q;
  assign out_oor   = out_oor_q;

endmodule

// File: tb/tb_lut_coeff_bank.sv
// Randomized bench for lut_coeff_bank against a table/queue reference model.
module tb_lut_coeff_bank;

  localparam int NC  = 2;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 5;
  localparam int TW  = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst, rd_valid, ld_start, ld_valid;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] rd_tag;
  logic [DW-1:0] ld_data;
  logic          rd_ready, out_valid, out_oor, ld_ready, ld_done;
  logic [NC*DW-1:0] out_q;
  logic [TW-1:0]    out_tag;

  lut_coeff_bank #(
    .NUM_COEFF(NC), .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .clock(clock), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .out_valid(out_valid), .out_q(out_q), .out_tag(out_tag), .out_oor(out_oor),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_done(ld_done)
  );

  typedef enum {P_IDLE, P_LOAD, P_DONE} phase_e;
  typedef struct {
    logic [NC*DW-1:0] q;
    logic [TW-1:0]    tag;
    logic             oor;
    int               cyc;
  } exp_t;

  phase_e        phase = P_IDLE;
  logic [DW-1:0] mem_m [DEP][NC];
  int            wa = 0, wc = 0;
  int            cyc = 0;
  bit            mon_en = 0;
  int            n_vec = 0, n_err = 0;
  exp_t          exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] exp_data(input int a);
    logic [NC*DW-1:0] r = '0;
    if (a < DEP) for (int c = 0; c < NC; c++) r[c*DW +: DW] = mem_m[a][c];
    return r;
  endfunction

  // One clock of stimulus; the model decides acceptance from its own phase.
  task automatic drive(input bit rv, input int ra, input int rt,
                       input bit ls, input bit lv, input logic [DW-1:0] ldat);
    phase_e nxt;
    chk("rd_ready", rd_ready, phase == P_IDLE);
    chk("ld_ready", ld_ready, phase == P_LOAD);
    chk("ld_done",  ld_done,  phase == P_DONE);
    rd_valid = rv; rd_addr = AW'(ra); rd_tag = TW'(rt);
    ld_start = ls; ld_valid = lv; ld_data = ldat;
    nxt = phase;
    case (phase)
      P_IDLE: begin
        if (rv) exp_q.push_back('{q: exp_data(ra), tag: TW'(rt), oor: (ra >= DEP), cyc: cyc + 2});
        if (ls) begin nxt = P_LOAD; wa = 0; wc = 0; end
      end
      P_LOAD: if (lv) begin
        mem_m[wa][wc] = ldat;
        if (wa == DEP-1 && wc == NC-1) nxt = P_DONE;
        else if (wc == NC-1) begin wc = 0; wa++; end
        else wc++;
      end
      default: nxt = P_IDLE;
    endcase
    @(posedge clock); #1;
    phase = nxt;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1; rd_valid = 0; ld_start = 0; ld_valid = 0;
    exp_q.delete();
    repeat (n) @(posedge clock);
    #1;
    phase = P_IDLE;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q",     out_q,     0);
    chk("rst_out_tag",   out_tag,   0);
    chk("rst_out_oor",   out_oor,   0);
    chk("rst_ld_done",   ld_done,   0);
    chk("rst_ld_ready",  ld_ready,  0);
    chk("rst_rd_ready",  rd_ready,  1);
    rst = 0;
  endtask

  // Streams n load words; noise reads and ld_start pulses must be ignored.
  task automatic load(input bit start, input bit rnd, input bit gaps, input int n);
    int sent = 0;
    if (start) drive(0, 0, 0, 1, 0, '0);
    while (sent < n) begin
      bit v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      logic [DW-1:0] d = rnd ? DW'($urandom) : DW'(wa * 16 + wc);
      drive(bit'($urandom_range(0, 1)), $urandom_range(0, DEP + 4), $urandom_range(0, 255),
            bit'($urandom_range(0, 1)), v, d);
      if (v) sent++;
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t x;
    bit   e;
    if (mon_en) begin
      e = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("out_valid", out_valid, e);
      if (e) begin
        x = exp_q.pop_front();
        chk("out_q",   out_q,   x.q);
        chk("out_tag", out_tag, x.tag);
        chk("out_oor", out_oor, x.oor);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 0; rd_valid = 0; rd_addr = '0; rd_tag = '0;
    ld_start = 0; ld_valid = 0; ld_data = '0;
    for (int a = 0; a < DEP; a++) for (int c = 0; c < NC; c++) mem_m[a][c] = '0;

    do_reset(2);
    mon_en = 1;

    // Full pattern load: word = addr*16 + ch, then read entry 5.
    load(1, 0, 0, NC * DEP);
    idle(2);
    drive(1, 5, 8'h55, 0, 0, '0);
    idle(1);
    // Back-to-back reads, then out-of-range addresses.
    drive(1, 0, 8'hA0, 0, 0, '0);
    drive(1, 1, 8'hA1, 0, 0, '0);
    drive(1, 2, 8'hA2, 0, 0, '0);
    drive(1, 16, 8'h33, 0, 0, '0);
    drive(1, 31, 8'h34, 0, 0, '0);
    idle(3);

    // ld_valid outside LOAD must not write.
    repeat (3) drive(0, 0, 0, 0, 1, DW'($urandom));

    // Read and ld_start together; reload with random data and 50% gaps.
    drive(1, 3, 8'h77, 1, 0, '0);
    load(0, 1, 1, NC * DEP);
    idle(2);

    repeat (60) drive(bit'($urandom_range(0, 1)), $urandom_range(0, DEP + 4),
                      $urandom_range(0, 255), 0, 0, '0);
    idle(3);

    // Abort a reload after 10 words.
    load(1, 1, 0, 10);
    do_reset(1);
    idle(3);
    for (int a = 0; a < DEP + 2; a++) drive(1, a, a + 8'h10, 0, 0, '0);
    idle(2);

    // Reload after abort still completes, with gaps and random data.
    load(1, 1, 1, NC * DEP);
    idle(2);
    for (int a = 0; a < DEP; a++) drive(1, a, 8'hC0 + a, 0, 0, '0);
    idle(5);
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
